// File: rtl/tlb_op_unit.sv
// Sequencer for the privileged TLB instructions (TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB).
// Accepts one op in IDLE, drives the TLB ports for one EXEC cycle, returns CSR write-back data in DONE.
module tlb_op_unit #(
  parameter int TLBNUM = 16,
  localparam int IW = $clog2(TLBNUM)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [2:0]    op_code,
  input  logic [4:0]    inv_op,
  input  logic [9:0]    inv_asid,
  input  logic [31:0]   inv_va,
  input  logic [IW-1:0] csr_index,
  input  logic [5:0]    csr_ps,
  input  logic          csr_ne,
  input  logic [18:0]   csr_vppn,
  input  logic [9:0]    csr_asid,
  input  logic [31:0]   csr_elo0,
  input  logic [31:0]   csr_elo1,
  input  logic [5:0]    csr_ecode,
  output logic [18:0]   s1_vppn,
  output logic          s1_va_bit12,
  output logic [9:0]    s1_asid,
  input  logic          s1_found,
  input  logic [IW-1:0] s1_index,
  output logic          invtlb_valid,
  output logic [4:0]    invtlb_op,
  output logic          we,
  output logic [IW-1:0] we_index,
  output logic          w_e,
  output logic [18:0]   w_vppn,
  output logic [5:0]    w_ps,
  output logic [9:0]    w_asid,
  output logic          w_g,
  output logic [19:0]   w_ppn0,
  output logic [1:0]    w_plv0,
  output logic [1:0]    w_mat0,
  output logic          w_d0,
  output logic          w_v0,
  output logic [19:0]   w_ppn1,
  output logic [1:0]    w_plv1,
  output logic [1:0]    w_mat1,
  output logic          w_d1,
  output logic          w_v1,
  output logic [IW-1:0] r_index,
  input  logic          r_e,
  input  logic [18:0]   r_vppn,
  input  logic [5:0]    r_ps,
  input  logic [9:0]    r_asid,
  input  logic          r_g,
  input  logic [19:0]   r_ppn0,
  input  logic [1:0]    r_plv0,
  input  logic [1:0]    r_mat0,
  input  logic          r_d0,
  input  logic          r_v0,
  input  logic [19:0]   r_ppn1,
  input  logic [1:0]    r_plv1,
  input  logic [1:0]    r_mat1,
  input  logic          r_d1,
  input  logic          r_v1,
  output logic          done,
  output logic          inv_err,
  output logic          wb_idx_we,
  output logic [IW-1:0] wb_index,
  output logic [5:0]    wb_ps,
  output logic          wb_ne,
  output logic          wb_ent_we,
  output logic [18:0]   wb_vppn,
  output logic [31:0]   wb_elo0,
  output logic [31:0]   wb_elo1,
  output logic [9:0]    wb_asid
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [2:0] OP_SRCH = 3'd0;
  localparam logic [2:0] OP_RD   = 3'd1;
  localparam logic [2:0] OP_WR   = 3'd2;
  localparam logic [2:0] OP_FILL = 3'd3;
  localparam logic [2:0] OP_INV  = 3'd4;

  state_t        state;
  logic [2:0]    op_q;
  logic [IW-1:0] idx_q;
  logic [5:0]    ps_q;
  logic          inv_bad_q;
  logic [IW-1:0] fill_cnt;

  assign op_ready = (state == IDLE);

  // TLB port registers are loaded at accept so they are stable for the whole EXEC cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      fill_cnt     <= '0;
      op_q         <= '0;
      idx_q        <= '0;
      ps_q         <= '0;
      inv_bad_q    <= 1'b0;
      s1_vppn      <= '0;
      s1_va_bit12  <= 1'b0;
      s1_asid      <= '0;
      invtlb_valid <= 1'b0;
      invtlb_op    <= '0;
      we           <= 1'b0;
      we_index     <= '0;
      w_e          <= 1'b0;
      w_vppn       <= '0;
      w_ps         <= '0;
      w_asid       <= '0;
      w_g          <= 1'b0;
      w_ppn0       <= '0;
      w_plv0       <= '0;
      w_mat0       <= '0;
      w_d0         <= 1'b0;
      w_v0         <= 1'b0;
      w_ppn1       <= '0;
      w_plv1       <= '0;
      w_mat1       <= '0;
      w_d1         <= 1'b0;
      w_v1         <= 1'b0;
      r_index      <= '0;
      done         <= 1'b0;
      inv_err      <= 1'b0;
      wb_idx_we    <= 1'b0;
      wb_index     <= '0;
      wb_ps        <= '0;
      wb_ne        <= 1'b0;
      wb_ent_we    <= 1'b0;
      wb_vppn      <= '0;
      wb_elo0      <= '0;
      wb_elo1      <= '0;
      wb_asid      <= '0;
    end else begin
      fill_cnt     <= fill_cnt + 1'b1;
      we           <= 1'b0;
      invtlb_valid <= 1'b0;
      done         <= 1'b0;
      inv_err      <= 1'b0;
      wb_idx_we    <= 1'b0;
      wb_ent_we    <= 1'b0;
      case (state)
        IDLE: begin
          if (op_valid) begin
            state     <= EXEC;
            op_q      <= op_code;
            idx_q     <= csr_index;
            ps_q      <= csr_ps;
            inv_bad_q <= (inv_op > 5'd6);
            case (op_code)
              OP_SRCH: begin
                s1_vppn     <= csr_vppn;
                s1_asid     <= csr_asid;
                s1_va_bit12 <= 1'b0;
              end
              OP_RD: r_index <= csr_index;
              OP_WR, OP_FILL: begin
                we       <= 1'b1;
                we_index <= (op_code == OP_WR) ? csr_index : fill_cnt;
                w_e      <= (csr_ecode == 6'h3F) | ~csr_ne;
                w_vppn   <= csr_vppn;
                w_ps     <= csr_ps;
                w_asid   <= csr_asid;
                w_g      <= csr_elo0[6] & csr_elo1[6];
                w_ppn0   <= csr_elo0[27:8];
                w_plv0   <= csr_elo0[3:2];
                w_mat0   <= csr_elo0[5:4];
                w_d0     <= csr_elo0[1];
                w_v0     <= csr_elo0[0];
                w_ppn1   <= csr_elo1[27:8];
                w_plv1   <= csr_elo1[3:2];
                w_mat1   <= csr_elo1[5:4];
                w_d1     <= csr_elo1[1];
                w_v1     <= csr_elo1[0];
              end
              OP_INV: begin
                if (inv_op <= 5'd6) begin
                  invtlb_valid <= 1'b1;
                  invtlb_op    <= inv_op;
                  s1_asid      <= inv_asid;
                  s1_vppn      <= inv_va[31:13];
                  s1_va_bit12  <= inv_va[12];
                end
              end
              default: ;
            endcase
          end
        end
        EXEC: begin
          state <= DONE;
          done  <= 1'b1;
          case (op_q)
            OP_SRCH: begin
              wb_idx_we <= 1'b1;
              wb_ps     <= ps_q;
              wb_index  <= s1_found ? s1_index : idx_q;
              wb_ne     <= ~s1_found;
            end
            OP_RD: begin
              wb_idx_we <= 1'b1;
              wb_ent_we <= 1'b1;
              wb_index  <= idx_q;
              if (r_e) begin
                wb_ne   <= 1'b0;
                wb_ps   <= r_ps;
                wb_vppn <= r_vppn;
                wb_asid <= r_asid;
                wb_elo0 <= {4'b0, r_ppn0, 1'b0, r_g, r_mat0, r_plv0, r_d0, r_v0};
                wb_elo1 <= {4'b0, r_ppn1, 1'b0, r_g, r_mat1, r_plv1, r_d1, r_v1};
              end else begin
                wb_ne   <= 1'b1;
                wb_ps   <= '0;
                wb_vppn <= '0;
                wb_asid <= '0;
                wb_elo0 <= '0;
                wb_elo1 <= '0;
              end
            end
            OP_INV: inv_err <= inv_bad_q;
            default: ;
          endcase
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/tlb_op_unit.md
Name: tlb_op_unit

Overview:
- Sequencer for the privileged TLB instructions TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB.
- Sits between the EXE/MEM pipeline stage and the TLB array. It takes one instruction per handshake, drives the TLB search port 1, read port, write port and invtlb port for exactly one cycle, then returns CSR write-back data (TLBIDX/TLBEHI/TLBELO0/TLBELO1/ASID) with a one-cycle done pulse.
- The pipeline holds the instruction until done.

Parameters:
- TLBNUM, 16, number of TLB entries.
- IW = $clog2(TLBNUM), localparam, index width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- op_valid  in  1  instruction request.
- op_ready  out  1  high only in IDLE.
- op_code  in  3  0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV; 5-7 are reserved and treated as no-op.
- inv_op  in  5  INVTLB op field.
- inv_asid  in  10  INVTLB rj[9:0].
- inv_va  in  32  INVTLB rk.
- csr_index  in  IW  TLBIDX.INDEX.
- csr_ps  in  6  TLBIDX.PS.
- csr_ne  in  1  TLBIDX.NE.
- csr_vppn  in  19  TLBEHI.VPPN.
- csr_asid  in  10  ASID.ASID.
- csr_elo0, csr_elo1  in  32 each  TLBELO layout: V[0] D[1] PLV[3:2] MAT[5:4] G[6] PPN[27:8].
- csr_ecode  in  6  ESTAT.Ecode; 0x3F means TLB refill is in progress.
- s1_vppn, s1_va_bit12, s1_asid  out  19, 1, 10  TLB search port 1.
- s1_found, s1_index  in  1, IW  TLB search result.
- invtlb_valid, invtlb_op  out  1, 5  TLB invalidate port.
- we, we_index  out  1, IW  TLB write enable and index.
- w_e, w_vppn, w_ps, w_asid, w_g, w_ppn0/1, w_plv0/1, w_mat0/1, w_d0/1, w_v0/1  out  widths as the TLB write port.
- r_index  out  IW  TLB read index.
- r_e, r_vppn, r_ps, r_asid, r_g, r_ppn0/1, r_plv0/1, r_mat0/1, r_d0/1, r_v0/1  in  TLB read data.
- done  out  1  one-cycle completion pulse.
- inv_err  out  1  valid with done; set for INVTLB with op>6, pipeline raises INE.
- wb_idx_we  out  1  write TLBIDX.INDEX/PS/NE.
- wb_index, wb_ps, wb_ne  out  IW, 6, 1.
- wb_ent_we  out  1  write TLBEHI, TLBELO0/1 and ASID.ASID.
- wb_vppn, wb_elo0, wb_elo1, wb_asid  out  19, 32, 32, 10.

Behaviour:
- FSM states: IDLE -> EXEC -> DONE -> IDLE.
  - IDLE: op_ready=1. On op_valid, register op_code, inv fields, all csr_* and the fill index; go to EXEC.
  - EXEC lasts one cycle and drives the TLB ports from the registered operands only.
  - DONE lasts one cycle: done=1 and the wb_* fields are valid.
- Latency: accept in cycle N, TLB access in N+1, done in N+2. Back-to-back accept is possible in N+3.
- op_valid outside IDLE is ignored.
- Fill counter: free-running IW-bit counter, +1 every cycle, wraps at TLBNUM-1 to 0 (power of two). It is sampled at accept.
- SRCH (EXEC):
  - Drive s1_vppn=csr_vppn, s1_asid=csr_asid, s1_va_bit12=0.
  - Register found/index.
  - DONE: wb_idx_we=1. Found: wb_index=s1_index, wb_ne=0. Not found: wb_index=csr_index, wb_ne=1. wb_ps=csr_ps.
- RD:
  - Drive r_index=csr_index and register r_* in EXEC.
  - If r_e=1: wb_ne=0, wb_ps=r_ps, wb_ent_we=1, wb_vppn=r_vppn, wb_asid=r_asid. wb_elo0/1 are packed from r_*0/1, with G=r_g in both.
  - If r_e=0: wb_ne=1, wb_ps=0, wb_ent_we=1, and vppn/elo/asid are all 0.
  - In both cases wb_idx_we=1 and wb_index=csr_index.
- WR/FILL:
  - we=1 for the EXEC cycle only. we_index=csr_index for WR; it is the sampled counter for FILL.
  - w_e = (csr_ecode==0x3F) ? 1 : !csr_ne.
  - w_vppn=csr_vppn, w_ps=csr_ps, w_asid=csr_asid.
  - w_g = elo0.G & elo1.G. The remaining fields are unpacked from csr_elo0/1.
  - No wb_*_we.
- INV:
  - If inv_op<=6: invtlb_valid=1 for the EXEC cycle, invtlb_op=inv_op, s1_asid=inv_asid, s1_vppn=inv_va[31:13], s1_va_bit12=inv_va[12].
  - If inv_op>6: invtlb_valid stays 0 and inv_err=1 at done.
- Reserved op_code values 5-7 complete with done and no side effects.
- Outside EXEC, we=0 and invtlb_valid=0. s1_* and r_index hold their last driven value.
- Reset:
  - State IDLE, counter 0, all registered outputs 0: done, inv_err, wb_* and we/invtlb_valid are low.
  - Reset asserted in EXEC or DONE cancels the operation: no we/invtlb pulse in the next cycle and no done.

Test Plan:
- Reset, then SRCH with csr_vppn=0x12345, asid=5, TLB returning found=1, index=7 -> done at N+2, wb_idx_we=1, wb_index=7, wb_ne=0.
- SRCH with found=0, csr_index=3 -> wb_index=3, wb_ne=1, wb_ent_we=0.
- RD index 2: with r_e=1, r_ps=21, r_ppn0=0xABCDE -> wb_ne=0, wb_ps=21, wb_elo0[27:8]=0xABCDE. With r_e=0 -> wb_ne=1, wb_elo0=0, wb_elo1=0, wb_asid=0.
- WR with csr_index=9, csr_ne=1, ecode=0: we pulses one cycle, we_index=9, w_e=0. Repeat with ecode=0x3F -> w_e=1. FILL issued 5 cycles after reset -> we_index=5.
- INV inv_op=5, inv_asid=0x3, inv_va=0x0040_3000 -> invtlb_valid for one cycle, s1_vppn=0x00201, s1_va_bit12=1. inv_op=7 -> no invtlb_valid, inv_err=1 with done.
- WR accepted, reset asserted in EXEC -> no done and no we in the next cycle. op_valid held during EXEC/DONE is not re-accepted until IDLE.
